// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: next-PC select encodings, NOP word, reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'b00,
        PC_SRC_BRANCH = 2'b01,
        PC_SRC_JUMP   = 2'b10,
        PC_SRC_JR     = 2'b11
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/decode controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if #(
    parameter int WIDTH = 32
);
    logic             stall_f;
    logic             stall_d;
    logic             flush_d;
    logic [1:0]       pc_src_d;
    logic [WIDTH-1:0] pc_branch_d;
    logic [WIDTH-1:0] pc_jump_d;
    logic [WIDTH-1:0] pc_jr_d;
    logic [WIDTH-1:0] instr_f;
    logic [WIDTH-1:0] pc_f;
    logic [WIDTH-1:0] instr_d;
    logic [WIDTH-1:0] pc_plus4_d;
    logic             valid_d;

    // Environment side: hazard unit, decode and instruction memory.
    modport master (
        output stall_f, stall_d, flush_d, pc_src_d,
        output pc_branch_d, pc_jump_d, pc_jr_d, instr_f,
        input  pc_f, instr_d, pc_plus4_d, valid_d
    );

    modport slave (
        input  stall_f, stall_d, flush_d, pc_src_d,
        input  pc_branch_d, pc_jump_d, pc_jr_d, instr_f,
        output pc_f, instr_d, pc_plus4_d, valid_d
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline register with rst > flush > stall > load priority; flush inserts a bubble.
module if_id_reg #(
    parameter int                  DATA_W      = 64,
    parameter logic [DATA_W-1:0]   BUBBLE_DATA = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_stall,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);
    logic [DATA_W-1:0] r_data;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_data  <= BUBBLE_DATA;
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_data  <= i_data;
            r_valid <= i_valid;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC mux and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.slave  bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]   fetch_cnt_o,
    output logic [31:0]   bubble_cnt_o
`endif
);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    logic [WIDTH-1:0]   r_pc;
    logic [WIDTH-1:0]   w_pc_plus4;
    logic [WIDTH-1:0]   w_pc_sel;
    logic [WIDTH-1:0]   w_pc_next;
    logic [2*WIDTH-1:0] w_if_id_data;

    assign w_pc_plus4 = r_pc + WIDTH'(4);

    always_comb begin
        w_pc_sel = w_pc_plus4;
        case (pc_src_e'(bus.pc_src_d))
            PC_SRC_SEQ:    w_pc_sel = w_pc_plus4;
            PC_SRC_BRANCH: w_pc_sel = bus.pc_branch_d;
            PC_SRC_JUMP:   w_pc_sel = bus.pc_jump_d;
            PC_SRC_JR:     w_pc_sel = bus.pc_jr_d;
            default:       w_pc_sel = w_pc_plus4;
        endcase
        w_pc_next = w_pc_sel & ALIGN_MASK;
    end

    // A held PC drops the redirect; the hazard unit reasserts it until fetch proceeds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (!bus.stall_f) begin
            r_pc <= w_pc_next;
        end
    end

    assign bus.pc_f = r_pc;

    if_id_reg #(
        .DATA_W      (2*WIDTH),
        .BUBBLE_DATA ({WIDTH'(NOP_INSTR), WIDTH'(0)})
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush_d),
        .i_stall (bus.stall_d),
        .i_valid (1'b1),
        .i_data  ({bus.instr_f, w_pc_plus4}),
        .o_data  (w_if_id_data),
        .o_valid (bus.valid_d)
    );

    assign bus.instr_d    = w_if_id_data[2*WIDTH-1:WIDTH];
    assign bus.pc_plus4_d = w_if_id_data[WIDTH-1:0];

`ifdef FETCH_PERF_CNT_EN
    // Index 0 counts IF/ID loads, index 1 counts flush or PC-stall cycles.
    logic [1:0] w_cnt_inc;
    assign w_cnt_inc[0] = !bus.flush_d && !bus.stall_d;
    assign w_cnt_inc[1] = bus.flush_d || bus.stall_f;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [31:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= 32'h0;
            end else if (w_cnt_inc[gi] && (r_cnt != 32'hFFFF_FFFF)) begin
                r_cnt <= r_cnt + 32'h1;
            end
        end
    end

    assign fetch_cnt_o  = g_cnt[0].r_cnt;
    assign bubble_cnt_o = g_cnt[1].r_cnt;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: table of per-cycle vectors fed through a scoreboard queue.
module tb_fetch_stage;
    import mips_pkg::*;

    logic clk;
    logic rst;

    fetch_stage_if #(.WIDTH(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] bubble_cnt;
`endif

    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o  (fetch_cnt),
        .bubble_cnt_o (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: word at byte address A is 0x1000_0000 + A/4.
    always_comb bus.instr_f = 32'h1000_0000 + {2'b00, bus.pc_f[31:2]};

    typedef struct {
        logic        rst;
        logic        sf;
        logic        sd;
        logic        fl;
        logic [1:0]  src;
        logic [31:0] br;
        logic [31:0] jp;
        logic [31:0] jr;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [31:0] ep4;
        logic        ev;
    } vec_t;

    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_txn   = 0;

    function automatic vec_t row(logic r, logic sf, logic sd, logic fl, logic [1:0] src,
                                 logic [31:0] tgt, logic [31:0] epc, logic [31:0] ein,
                                 logic [31:0] ep4, logic ev);
        vec_t v;
        v.rst = r; v.sf = sf; v.sd = sd; v.fl = fl; v.src = src;
        v.br = 32'hBAD0_0100; v.jp = 32'hBAD0_0200; v.jr = 32'hBAD0_0300;
        if (src == 2'b01) v.br = tgt;
        if (src == 2'b10) v.jp = tgt;
        if (src == 2'b11) v.jr = tgt;
        v.epc = epc; v.ein = ein; v.ep4 = ep4; v.ev = ev;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s txn %0d: got %h expected %h", name, n_txn, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst             = v.rst;
        bus.stall_f     = v.sf;
        bus.stall_d     = v.sd;
        bus.flush_d     = v.fl;
        bus.pc_src_d    = v.src;
        bus.pc_branch_d = v.br;
        bus.pc_jump_d   = v.jp;
        bus.pc_jr_d     = v.jr;
        sb.push_back(v);
        @(posedge clk);
        #1;
        n_txn++;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL scoreboard txn %0d: got empty queue expected entry", n_txn);
        end else begin
            e = sb.pop_front();
            $display("[TB] txn %0d rst=%b sf=%b sd=%b fl=%b src=%b -> pc_f=%h instr_d=%h pc_plus4_d=%h valid_d=%b",
                     n_txn, e.rst, e.sf, e.sd, e.fl, e.src, bus.pc_f, bus.instr_d, bus.pc_plus4_d, bus.valid_d);
            chk("pc_f",       bus.pc_f,       e.epc);
            chk("instr_d",    bus.instr_d,    e.ein);
            chk("pc_plus4_d", bus.pc_plus4_d, e.ep4);
            chk("valid_d",    {31'h0, bus.valid_d}, {31'h0, e.ev});
        end
    endtask

    vec_t tbl[22];

    initial begin
        rst = 1'b1;
        bus.stall_f = 1'b0; bus.stall_d = 1'b0; bus.flush_d = 1'b0;
        bus.pc_src_d = PC_SRC_SEQ;
        bus.pc_branch_d = '0; bus.pc_jump_d = '0; bus.pc_jr_d = '0;

        //              rst   sf    sd    fl    src    tgt            pc             instr_d        pc+4           v
        tbl[0]  = row(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0);
        tbl[1]  = row(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h0,         32'h0,         1'b0);
        tbl[2]  = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h1000_0000, 32'h4,         1'b1);
        tbl[3]  = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h8,         32'h1000_0001, 32'h8,         1'b1);
        tbl[4]  = row(1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 32'h40,        32'h40,        32'h0,         32'h0,         1'b0);
        tbl[5]  = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h44,        32'h1000_0010, 32'h44,        1'b1);
        tbl[6]  = row(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0F,        32'h0C,        32'h0,         32'h0,         1'b0);
        tbl[7]  = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h10,        32'h1000_0003, 32'h10,        1'b1);
        tbl[8]  = row(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h80,        32'h10,        32'h1000_0003, 32'h10,        1'b1);
        tbl[9]  = row(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h80,        32'h10,        32'h1000_0003, 32'h10,        1'b1);
        tbl[10] = row(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 32'h80,        32'h10,        32'h1000_0003, 32'h10,        1'b1);
        tbl[11] = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h14,        32'h1000_0004, 32'h14,        1'b1);
        tbl[12] = row(1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0,         32'h18,        32'h0,         32'h0,         1'b0);
        tbl[13] = row(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'h127,       32'h124,       32'h0,         32'h0,         1'b0);
        tbl[14] = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h128,       32'h1000_0049, 32'h128,       1'b1);
        tbl[15] = row(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b0);
        tbl[16] = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0,         32'h4FFF_FFFF, 32'h0,         1'b1);
        tbl[17] = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h1000_0000, 32'h4,         1'b1);
        tbl[18] = row(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 32'h200,       32'h0,         32'h0,         32'h0,         1'b0);
        tbl[19] = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h1000_0000, 32'h4,         1'b1);
        tbl[20] = row(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 32'h0,         32'h4,         32'h1000_0001, 32'h8,         1'b1);
        tbl[21] = row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,         32'h8,         32'h1000_0001, 32'h8,         1'b1);

        for (int i = 0; i < 22; i++) step(tbl[i]);

        // Reset held with arbitrary controls must keep the reset state every cycle.
        for (int i = 0; i < 3; i++) begin
            step(row(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom(),
                     32'h0, 32'h0, 32'h0, 1'b0));
        end
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_rst",  fetch_cnt,  32'd0);
        chk("bubble_cnt_rst", bubble_cnt, 32'd0);
`endif

        // Five sequential fetches from the reset vector.
        for (int k = 1; k <= 5; k++) begin
            step(row(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0,
                     32'(4 * k), 32'h1000_0000 + 32'(k - 1), 32'(4 * k), 1'b1));
        end
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_5",  fetch_cnt,  32'd5);
        chk("bubble_cnt_0", bubble_cnt, 32'd0);
`endif

        // Lone flush without redirect: bubble, PC still advances.
        step(row(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h18, 32'h0, 32'h0, 1'b0));
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt_hold", fetch_cnt,  32'd5);
        chk("bubble_cnt_1",   bubble_cnt, 32'd1);
`endif

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
